vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line.
REQ-002 Parameter H_SYNC, 96, hsync pulse width in clocks.
REQ-003 Parameter H_BP, 48, horizontal back porch in clocks.
REQ-004 Parameter V_ACTIVE, 480, active lines per frame.
REQ-005 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-006 Parameter V_BP, 33, vertical back porch in lines.
REQ-007 iClk  input  1  pixel clock; one pixel per rising edge; the only clock.
REQ-008 iRst  input  1  synchronous, active-high reset.
REQ-009 hsync  input  1  horizontal sync, active low.
REQ-010 vsync  input  1  vertical sync, active low.
REQ-011 R, G, B  input  4 each  pixel colour.
REQ-012 iStart  input  1  single-cycle pulse that arms capture of the next full frame.
REQ-013 oBusy  output  1  high from accepted iStart until frame complete.
REQ-014 oDone  output  1  single-cycle pulse when the last pixel of the frame is written.
REQ-015 oWrEn  output  1  memory write strobe.
REQ-016 oWrAddr  output  19  linear pixel address.
REQ-017 oWrData  output  12  pixel data as {R,G,B}.

Function
REQ-018 hsync, vsync, R, G and B SHALL be registered once before any use; all timing below refers to this registered copy.
REQ-019 A sync falling edge SHALL be detected as previous sample high and current sample low.
REQ-020 hcnt SHALL load 0 on an hsync falling edge and otherwise increment, saturating at 2047.
REQ-021 vline SHALL load 0 on a vsync falling edge and otherwise increment on each hsync falling edge, saturating at 1023.
REQ-022 Pixel active SHALL mean H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vline < V_SYNC+V_BP+V_ACTIVE.
REQ-023 The FSM SHALL have states IDLE, ARMED, CAPTURE.
REQ-024 IDLE: on iStart go to ARMED and assert oBusy.
REQ-025 ARMED: on a vsync falling edge go to CAPTURE; a frame already in progress SHALL never be captured partially.
REQ-026 CAPTURE: for each active pixel, assert oWrEn for exactly one cycle, with oWrAddr = (vline-V_SYNC-V_BP)*H_ACTIVE + (hcnt-H_SYNC-H_BP) and oWrData = the registered {R,G,B} of that pixel.
REQ-027 oWrEn, oWrAddr and oWrData SHALL be registered, giving a latency of 2 clocks from the pixel at the input pins to its write strobe.
REQ-028 When the write to the last active address is issued, oDone SHALL pulse in that same cycle, oBusy SHALL fall on the next cycle, and the FSM SHALL return to IDLE.
REQ-029 iStart SHALL be ignored while oBusy is high.
REQ-030 A vsync falling edge during CAPTURE before frame end SHALL abort the frame: no oDone, FSM returns to ARMED, and capture restarts with the new frame.
REQ-031 oWrAddr SHALL hold its last value when oWrEn is low; outside CAPTURE oWrEn SHALL be 0.

Reset
REQ-032 While iRst is high at a rising edge: FSM=IDLE, hcnt=0, vline=1023, all input registers=1 (sync) or 0 (colour), oBusy=0, oDone=0, oWrEn=0, oWrAddr=0, oWrData=0.
REQ-033 Reset asserted mid-capture SHALL abandon the frame without an oDone pulse; the following iStart SHALL behave as from power-up.

Configuration
REQ-034 Macro VGA_CAPTURE_DECIM_EN defined: only pixels with even column and even line index within the active area are written, oWrAddr = (line/2)*(H_ACTIVE/2) + col/2 (76800 words for defaults), and oDone is issued with the write of (H_ACTIVE-2, V_ACTIVE-2).
REQ-035 Macro undefined: full resolution per REQ-026; oWrAddr upper bits unused by decimation remain 0 in decimated mode.

Structure
REQ-036 The default timing constants and the FSM state encoding SHALL reside in shared package vga_pkg, which is also used by the VGA output path.
REQ-037 Edge detection plus hcnt/vline tracking SHALL be one sub-module, vga_sync_tracker; the FSM and address generation SHALL stay in vga_capture.

Verification
REQ-038 Reset, then a 640x480 stream with pixel = address[11:0], iStart asserted mid-frame -> no writes until the next vsync falling edge; then 307200 writes with oWrData == oWrAddr[11:0] and one oDone.
REQ-039 First active pixel (hcnt 144, vline 35) driven as 0xABC -> oWrEn=1, oWrAddr=0, oWrData=0xABC exactly 2 clocks later.
REQ-040 iStart pulsed again while oBusy=1 -> ignored, exactly one frame captured.
REQ-041 vsync falling edge injected at vline 200 of a captured frame -> no oDone, capture restarts at address 0 on the next frame.
REQ-042 iRst asserted for 1 cycle at mid-line 100 -> all outputs 0 the next cycle, and no further writes until a new iStart.
REQ-043 With VGA_CAPTURE_DECIM_EN -> 76800 writes, last address 76799, oDone coincident with that write.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and capture FSM state encoding, used by both the
// capture path and the VGA output path.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_FP_DEF     = 16;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_FP_DEF     = 10;

    localparam int HCNT_W  = 11;
    localparam int VLINE_W = 10;
    localparam int ADDR_W  = 19;
    localparam int PIX_W   = 12;

    localparam logic [HCNT_W-1:0]  HCNT_MAX  = '1;
    localparam logic [VLINE_W-1:0] VLINE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/vga_sync_tracker.sv
// Sync falling-edge detection and pixel/line position of the current registered
// sample. hcnt/vline are the position of the sample presented this cycle.
module vga_sync_tracker
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               hs,
    input  logic               vs,
    output logic [HCNT_W-1:0]  hcnt,
    output logic [VLINE_W-1:0] vline,
    output logic               vfall
);

    logic               hs_d;
    logic               vs_d;
    logic               hfall;
    logic [HCNT_W-1:0]  hcnt_q;
    logic [VLINE_W-1:0] vline_q;

    assign hfall = hs_d & ~hs;
    assign vfall = vs_d & ~vs;

    always_comb begin
        hcnt  = hcnt_q;
        vline = vline_q;
        if (hfall) begin
            hcnt = '0;
        end else if (hcnt_q != HCNT_MAX) begin
            hcnt = hcnt_q + 1'b1;
        end
        if (vfall) begin
            vline = '0;
        end else if (hfall && vline_q != VLINE_MAX) begin
            vline = vline_q + 1'b1;
        end
    end

    // vline resets to its saturated value so nothing looks active before the first vsync.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            hcnt_q  <= '0;
            vline_q <= VLINE_MAX;
        end else begin
            hs_d    <= hs;
            vs_d    <= vs;
            hcnt_q  <= hcnt;
            vline_q <= vline;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// Frame grabber: arms on iStart, writes one full frame to memory as {R,G,B} words.
// Define VGA_CAPTURE_DECIM_EN to write only even columns/lines (2x2 decimation).
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [3:0]        R,
    input  logic [3:0]        G,
    input  logic [3:0]        B,
    input  logic              iStart,
    output logic              oBusy,
    output logic              oDone,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [PIX_W-1:0]  oWrData,
    output logic [1:0]        fsm_state
);

    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    logic               hs_r;
    logic               vs_r;
    logic [PIX_W-1:0]   rgb_r;
    logic [HCNT_W-1:0]  hcnt;
    logic [VLINE_W-1:0] vline;
    logic               vfall;
    logic [HCNT_W-1:0]  col;
    logic [VLINE_W-1:0] row;
    logic               active;
    logic               take;
    logic               last;
    logic [ADDR_W-1:0]  addr;
    cap_state_t         state;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            hs_r  <= 1'b1;
            vs_r  <= 1'b1;
            rgb_r <= '0;
        end else begin
            hs_r  <= hsync;
            vs_r  <= vsync;
            rgb_r <= {R, G, B};
        end
    end

    vga_sync_tracker u_tracker (
        .clk   (iClk),
        .rst   (iRst),
        .hs    (hs_r),
        .vs    (vs_r),
        .hcnt  (hcnt),
        .vline (vline),
        .vfall (vfall)
    );

    assign col    = hcnt - HCNT_W'(H_START);
    assign row    = vline - VLINE_W'(V_START);
    assign active = (hcnt >= HCNT_W'(H_START)) && (hcnt < HCNT_W'(H_START + H_ACTIVE)) &&
                    (vline >= VLINE_W'(V_START)) && (vline < VLINE_W'(V_START + V_ACTIVE));

`ifdef VGA_CAPTURE_DECIM_EN
    assign take = active && !col[0] && !row[0];
    assign addr = ADDR_W'(row[VLINE_W-1:1]) * ADDR_W'(H_ACTIVE / 2) + ADDR_W'(col[HCNT_W-1:1]);
    assign last = (col == HCNT_W'(H_ACTIVE - 2)) && (row == VLINE_W'(V_ACTIVE - 2));
`else
    assign take = active;
    assign addr = ADDR_W'(row) * ADDR_W'(H_ACTIVE) + ADDR_W'(col);
    assign last = (col == HCNT_W'(H_ACTIVE - 1)) && (row == VLINE_W'(V_ACTIVE - 1));
`endif

    // Write port is a strobe with no backpressure: oWrAddr/oWrData are valid only
    // in a cycle with oWrEn high, and the memory must accept every strobe.
    // ARMED waits for vline==0, which only holds in the line started by a vsync
    // falling edge, so a frame already under way is never entered part-way.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= ST_IDLE;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oWrEn   <= 1'b0;
            oWrAddr <= '0;
            oWrData <= '0;
        end else begin
            oWrEn <= 1'b0;
            oDone <= 1'b0;
            if (oDone) begin
                oBusy <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (iStart && !oBusy) begin
                        state <= ST_ARMED;
                        oBusy <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (vline == '0) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (vfall) begin
                        state <= ST_ARMED;
                    end else if (take) begin
                        oWrEn   <= 1'b1;
                        oWrAddr <= addr;
                        oWrData <= rgb_r;
                        if (last) begin
                            oDone <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced 16x8 raster: frame-level model of which
// pixels must be written and when, checked against the DUT every cycle.
module tb_vga_capture;
    import vga_pkg::*;

    localparam int HA = 16;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HF = 2;
    localparam int VA = 8;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VF = 2;
    localparam int LINE_LEN = HS + HB + HA + HF;
    localparam int FRAME_LINES = VS + VB + VA + VF;

`ifdef VGA_CAPTURE_DECIM_EN
    localparam int SC1_WR = 32;
    localparam int SC2_WR = 48;
    localparam int SC3_WR = 42;
`else
    localparam int SC1_WR = 128;
    localparam int SC2_WR = 176;
    localparam int SC3_WR = 164;
`endif

    logic        iClk = 1'b0;
    logic        iRst;
    logic        hsync;
    logic        vsync;
    logic [3:0]  R;
    logic [3:0]  G;
    logic [3:0]  B;
    logic        iStart;
    logic        oBusy;
    logic        oDone;
    logic        oWrEn;
    logic [18:0] oWrAddr;
    logic [11:0] oWrData;
    logic [1:0]  fsm_state;

    // Clock / reset
    always #5 iClk = ~iClk;

    vga_capture #(
        .H_ACTIVE (HA),
        .H_SYNC   (HS),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .hsync     (hsync),
        .vsync     (vsync),
        .R         (R),
        .G         (G),
        .B         (B),
        .iStart    (iStart),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .fsm_state (fsm_state)
    );

    // Scoreboard: {cycle, done, addr, data} of every write the model expects
    logic [63:0] exp_q[$];
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int wr_seen = 0;
    int done_seen = 0;
    int abc_cyc = -10;

    // Frame-level model state
    bit armed = 0;
    bit capturing = 0;
    int busy_from = -1;
    int busy_until = -1;

    function automatic bit busy_exp(input int c);
        return busy_from >= 0 && c >= busy_from && (busy_until < 0 || c < busy_until);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, want);
        end
    endtask

    // Driver tasks
    task automatic tick(input logic hs, input logic vs, input logic [11:0] pix,
                        input logic st, input logic rs);
        @(posedge iClk);
        cyc++;
        #1;
        hsync  = hs;
        vsync  = vs;
        {R, G, B} = pix;
        iStart = st;
        iRst   = rs;
    endtask

    task automatic push_pixel(input int col, input int row, input logic [11:0] pix);
        logic [18:0] a;
        bit          last;
`ifdef VGA_CAPTURE_DECIM_EN
        if ((col % 2) != 0 || (row % 2) != 0) return;
        a    = 19'((row / 2) * (HA / 2) + col / 2);
        last = (col == HA - 2) && (row == VA - 2);
`else
        a    = 19'(row * HA + col);
        last = (col == HA - 1) && (row == VA - 1);
`endif
        exp_q.push_back({32'(cyc + 2), last, a, pix});
        if (last) begin
            capturing  = 0;
            busy_until = cyc + 3;
        end
    endtask

    task automatic frame(input int n_lines, input int salt, input int st_line, input int st_x,
                         input int rs_line, input int rs_x, input bit mark_abc);
        for (int y = 0; y < n_lines; y++) begin
            for (int x = 0; x < LINE_LEN; x++) begin
                int          col;
                int          row;
                bit          act;
                bit          st;
                bit          rs;
                logic [11:0] pix;
                col = x - HS - HB;
                row = y - VS - VB;
                act = col >= 0 && col < HA && row >= 0 && row < VA;
                st  = (y == st_line) && (x == st_x);
                rs  = (y == rs_line) && (x == rs_x);
                if (act) pix = 12'(row * HA + col + salt);
                else     pix = 12'($urandom_range(0, 4095));
                if (act && mark_abc && row == 0 && col == 0) pix = 12'hABC;
                tick(x >= HS, y >= VS, pix, st, rs);
                if (x == 0 && y == 0 && armed) begin
                    capturing = 1;
                    armed     = 0;
                end
                if (st && !busy_exp(cyc)) begin
                    armed      = 1;
                    busy_from  = cyc + 1;
                    busy_until = -1;
                end
                if (rs) begin
                    armed     = 0;
                    capturing = 0;
                    if (busy_from >= 0 && busy_until < 0) busy_until = cyc + 1;
                    while (exp_q.size() > 0 && int'(exp_q[$][63:32]) >= cyc + 1)
                        void'(exp_q.pop_back());
                end else if (act && capturing) begin
                    push_pixel(col, row, pix);
                end
                if (act && mark_abc && row == 0 && col == 0) abc_cyc = cyc;
            end
        end
    endtask

    task automatic end_scenario(input string name, input int want_wr);
        check({name, "_writes"}, wr_seen, want_wr);
        check({name, "_dones"}, done_seen, 1);
        wr_seen   = 0;
        done_seen = 0;
    endtask

    // Compare process: checks every output on every cycle
    initial begin : compare
        bit          rst_last;
        logic [18:0] hold_addr;
        logic [63:0] e;
        bit          e_en;
        rst_last  = 1;
        hold_addr = '0;
        forever begin
            @(negedge iClk);
            if (oWrEn === 1'b1) wr_seen++;
            if (oDone === 1'b1) done_seen++;
            if (rst_last) begin
                check("rst_busy", oBusy, 0);
                check("rst_done", oDone, 0);
                check("rst_wr_en", oWrEn, 0);
                check("rst_wr_addr", oWrAddr, 0);
                check("rst_wr_data", oWrData, 0);
                check("rst_state", fsm_state, 32'(ST_IDLE));
                hold_addr = '0;
            end else begin
                e_en = 0;
                e    = '0;
                if (exp_q.size() > 0 && int'(exp_q[0][63:32]) == cyc) begin
                    e    = exp_q.pop_front();
                    e_en = 1;
                end
                check("wr_en", oWrEn, 32'(e_en));
                check("done", oDone, 32'(e[31]));
                check("busy", oBusy, 32'(busy_exp(cyc)));
                if (e_en) begin
                    check("wr_addr", oWrAddr, 32'(e[30:12]));
                    check("wr_data", oWrData, 32'(e[11:0]));
                    hold_addr = e[30:12];
                end else begin
                    check("addr_hold", oWrAddr, 32'(hold_addr));
                end
                if (cyc == abc_cyc + 2) begin
                    check("first_px_en", oWrEn, 1);
                    check("first_px_addr", oWrAddr, 0);
                    check("first_px_data", oWrData, 32'h0ABC);
                end
            end
            rst_last = iRst;
        end
    end

    // Stimulus
    initial begin : driver
        iRst   = 1'b1;
        hsync  = 1'b1;
        vsync  = 1'b1;
        R      = '0;
        G      = '0;
        B      = '0;
        iStart = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 12'h000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 12'h000, 1'b0, 1'b0);

        // Arm mid-frame, capture the next frame, second iStart ignored
        frame(FRAME_LINES, 0, 7, 10, -1, -1, 1'b0);
        frame(FRAME_LINES, 0, 9, 5, -1, -1, 1'b1);
        frame(FRAME_LINES, 0, -1, -1, -1, -1, 1'b0);
        end_scenario("arm_mid_frame", SC1_WR);

        // Early vsync aborts the frame; capture restarts on the next one
        frame(FRAME_LINES, 0, 10, 3, -1, -1, 1'b0);
        frame(8, 5, -1, -1, -1, -1, 1'b0);
        frame(FRAME_LINES, 5, -1, -1, -1, -1, 1'b0);
        end_scenario("vsync_abort", SC2_WR);

        // Reset mid-capture, then a fresh iStart after reset
        frame(FRAME_LINES, 0, 12, 20, -1, -1, 1'b0);
        frame(FRAME_LINES, 9, -1, -1, 7, 12, 1'b0);
        frame(FRAME_LINES, 0, 3, 1, -1, -1, 1'b0);
        frame(FRAME_LINES, 300, -1, -1, -1, -1, 1'b0);
        end_scenario("reset_mid", SC3_WR);

        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
